// File: rtl/ref_read_scheduler.sv
// Per-port DRAM read scheduler: splits a block job into credit-gated bursts and buffers the returned data.
// Optional macro REF_READ_4K_SPLIT_EN keeps every burst inside one 4 KiB page.
module ref_read_scheduler #(
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned FIFO_DEPTH = 64,
  parameter logic [5:0]  BURST_ID   = 6'd0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_in,
  input  logic [32:0]  start_addr_in,
  input  logic [31:0]  num_blocks_in,
  output logic         busy_out,
  output logic         done_out,
  output logic [5:0]   rd_id_out,
  output logic [32:0]  rd_addr_out,
  output logic [7:0]   rd_len_out,
  output logic         rd_info_valid_out,
  input  logic         rd_info_rdy_in,
  input  logic [255:0] rd_data_in,
  input  logic         rd_data_valid_in,
  output logic         rd_data_rdy_out,
  output logic [255:0] blk_data_out,
  output logic         blk_valid_out,
  input  logic         blk_rdy_in
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

  state_t         state_q, state_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           info_valid_q, info_valid_d;
  logic [32:0]    rd_addr_q, rd_addr_d;
  logic [7:0]     rd_len_q, rd_len_d;
  logic [32:0]    req_addr_q, req_addr_d;
  logic [31:0]    req_left_q, req_left_d;
  logic [CW-1:0]  credits_q, credits_d;
  logic [31:0]    deliv_left_q, deliv_left_d;
  logic [AW:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]    rd_ptr_q, rd_ptr_d;
  logic [255:0]   mem [FIFO_DEPTH];

  logic           fifo_full, fifo_empty;
  logic           push, pop, issue_hs;
  logic [8:0]     blen, pend_blen;
  logic [31:0]    room;
`ifdef REF_READ_4K_SPLIT_EN
  logic [8:0]     page_room;
`endif

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Size of the next burst from the current request pointer
  always_comb begin
    blen = 9'(MAX_BURST);
    if (req_left_q < 32'(MAX_BURST)) begin
      blen = req_left_q[8:0];
    end
`ifdef REF_READ_4K_SPLIT_EN
    page_room = 9'd128 - {2'b00, req_addr_q[11:5]};
    if (page_room < blen) begin
      blen = page_room;
    end
`endif
    room      = 32'(FIFO_DEPTH) - 32'(credits_q);
    pend_blen = {1'b0, rd_len_q} + 9'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      info_valid_q <= 1'b0;
      rd_addr_q    <= '0;
      rd_len_q     <= '0;
      req_addr_q   <= '0;
      req_left_q   <= '0;
      credits_q    <= '0;
      deliv_left_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      info_valid_q <= info_valid_d;
      rd_addr_q    <= rd_addr_d;
      rd_len_q     <= rd_len_d;
      req_addr_q   <= req_addr_d;
      req_left_q   <= req_left_d;
      credits_q    <= credits_d;
      deliv_left_q <= deliv_left_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q[AW-1:0]] <= rd_data_in;
    end
  end

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = (state_q == FINISH);
    info_valid_d = info_valid_q;
    rd_addr_d    = rd_addr_q;
    rd_len_d     = rd_len_q;
    req_addr_d   = req_addr_q;
    req_left_d   = req_left_q;
    deliv_left_d = deliv_left_q;
    issue_hs     = info_valid_q & rd_info_rdy_in;
    wr_ptr_d     = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d     = rd_ptr_q + (AW+1)'(pop);
    credits_d    = credits_q + (issue_hs ? CW'(pend_blen) : '0) - CW'(pop);
    if (pop) begin
      deliv_left_d = deliv_left_q - 32'd1;
    end

    case (state_q)
      IDLE: begin
        if (start_in) begin
          busy_d       = 1'b1;
          req_addr_d   = start_addr_in;
          req_left_d   = num_blocks_in;
          deliv_left_d = num_blocks_in;
          // An empty job passes through DRAIN (nothing to deliver) so its done
          // pulse follows the same pipeline as a normal completion.
          state_d      = (num_blocks_in == '0) ? DRAIN : ISSUE;
        end
      end
      ISSUE: begin
        if (issue_hs) begin
          info_valid_d = 1'b0;
          req_addr_d   = req_addr_q + (33'(pend_blen) << 5);
          req_left_d   = req_left_q - 32'(pend_blen);
          if (req_left_q == 32'(pend_blen)) begin
            state_d = DRAIN;
          end
        end else if (!info_valid_q && (room >= 32'(blen))) begin
          info_valid_d = 1'b1;
          rd_addr_d    = req_addr_q;
          rd_len_d     = 8'(blen - 9'd1);
        end
      end
      DRAIN: begin
        if (deliv_left_q == '0) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_out          = busy_q;
    done_out          = done_q;
    rd_id_out         = BURST_ID;
    rd_addr_out       = rd_addr_q;
    rd_len_out        = rd_len_q;
    rd_info_valid_out = info_valid_q;
    rd_data_rdy_out   = !fifo_full;
    blk_valid_out     = !fifo_empty;
    blk_data_out      = mem[rd_ptr_q[AW-1:0]];
    push              = rd_data_valid_in & !fifo_full;
    pop               = !fifo_empty & blk_rdy_in;
  end

  // Credits reserve room for every outstanding beat, so data never meets a full FIFO
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(rd_data_valid_in && fifo_full));

endmodule
